shift_sub_divide: RTL and testbench

Sequential unsigned restoring divider, the inverse of the team's shift-add multiplier. Takes a WIDTH-bit dividend and divisor and produces quotient and remainder in WIDTH clock cycles, one quotient bit per cycle. Uses the same start/ready handshake as the multiplier, so both can sit behind a common arithmetic-unit controller in the lab datapath.

---
 rtl/arith_pkg.sv | 8 +
 rtl/div_step.sv | 16 +
 rtl/shift_sub_divide.sv | 78 +++++++
 tb/tb_shift_sub_divide.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// arith_pkg: shared defaults and helpers for the sequential arithmetic units.
package arith_pkg;
    localparam int DEF_WIDTH = 16;

    function automatic int cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step on {R,Q} against D.
module div_step #(
    parameter int W = 16
) (
    input  logic [W-1:0] r_i,
    input  logic [W-1:0] q_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] r_o,
    output logic [W-1:0] q_o
);
    logic [W:0] rs, t;
    assign rs = {r_i, q_i[W-1]};
    assign t = rs - {1'b0, d_i};
    assign r_o = t[W] ? rs[W-1:0] : t[W-1:0];
    assign q_o = {q_i[W-2:0], ~t[W]};
endmodule

// File: rtl/shift_sub_divide.sv
// shift_sub_divide: unsigned restoring divider, one quotient bit per cycle, start/ready handshake.
module shift_sub_divide
    import arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready,
    output logic             done,
    output logic             div_by_zero
);
    localparam int CW = cnt_w(WIDTH);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d, q_q, q_d, d_q, d_d, r_step, q_step;
    logic done_q, done_d, dz_q, dz_d;

    // The partial remainder stays below D, so WIDTH bits suffice; the step widens it internally.
    div_step #(.W(WIDTH)) u_step (
        .r_i(r_q),
        .q_i(q_q),
        .d_i(d_q),
        .r_o(r_step),
        .q_o(q_step)
    );

    always_comb begin
        cnt_d = cnt_q;
        r_d = r_q;
        q_d = q_q;
        d_d = d_q;
        dz_d = dz_q;
        done_d = 1'b0;
        if (cnt_q != '0) begin
            r_d = r_step;
            q_d = q_step;
            cnt_d = cnt_q - CW'(1);
            done_d = (cnt_q == CW'(1));
        end else if (start) begin
            d_d = divisor;
            dz_d = (divisor == '0);
            done_d = (divisor == '0);
            r_d = (divisor == '0) ? dividend : '0;
            q_d = (divisor == '0) ? '1 : dividend;
            cnt_d = (divisor == '0) ? '0 : CW'(WIDTH);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            r_q <= '0;
            q_q <= '0;
            d_q <= '0;
            done_q <= 1'b0;
            dz_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            r_q <= r_d;
            q_q <= q_d;
            d_q <= d_d;
            done_q <= done_d;
            dz_q <= dz_d;
        end
    end

    assign ready = (cnt_q == '0);
    assign done = done_q;
    assign div_by_zero = dz_q;
    assign quotient = q_q;
    assign remainder = r_q;
endmodule

// File: tb/tb_shift_sub_divide.sv
// tb_shift_sub_divide: vector table plus handshake corner cases, checked through a result scoreboard.
module tb_shift_sub_divide;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [W-1:0] dividend = '0, divisor = '0;
    logic [W-1:0] quotient, remainder;
    logic ready, done, div_by_zero;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [W-1:0] a, b, q, r;
        logic dz;
    } vec_t;

    typedef struct {
        logic [W-1:0] a, b, q, r;
        logic dz;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    vec_t vecs[12];

    shift_sub_divide #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .quotient(quotient),
        .remainder(remainder),
        .ready(ready),
        .done(done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    // Every done pulse must match the oldest outstanding request, on its predicted cycle.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: done=1 with no request outstanding at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", div_by_zero, e.dz);
                chk("ready_at_done", ready, 1);
                if (!e.dz) begin
                    chk("invariant", 32'(quotient) * 32'(e.b) + 32'(remainder), 32'(e.a));
                    chk("rem_lt_div", remainder < e.b, 1);
                end
            end
        end
    end

    task automatic wait_ready();
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (ready) break;
        end
        if (!ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: ready=%0b expected 1 at cycle %0d", ready, cyc);
        end
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 60 && sb.size() != 0; n++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: %0d results outstanding expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic push_exp(input logic [W-1:0] a, b, q, r, input logic dz);
        sb.push_back('{a: a, b: b, q: q, r: r, dz: dz, cyc: cyc + (dz ? 0 : W)});
    endtask

    task automatic do_op(input logic [W-1:0] a, b, q, r, input logic dz);
        wait_ready();
        dividend = a;
        divisor = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        push_exp(a, b, q, r, dz);
    endtask

    initial begin
        logic [W-1:0] a, b;
        vecs[0]  = '{a: 16'd100,   b: 16'd7,     q: 16'd14,    r: 16'd2,     dz: 1'b0};
        vecs[1]  = '{a: 16'hFFFF,  b: 16'd1,     q: 16'hFFFF,  r: 16'd0,     dz: 1'b0};
        vecs[2]  = '{a: 16'd3,     b: 16'd10,    q: 16'd0,     r: 16'd3,     dz: 1'b0};
        vecs[3]  = '{a: 16'd5,     b: 16'd0,     q: 16'hFFFF,  r: 16'd5,     dz: 1'b1};
        vecs[4]  = '{a: 16'd0,     b: 16'd5,     q: 16'd0,     r: 16'd0,     dz: 1'b0};
        vecs[5]  = '{a: 16'hFFFF,  b: 16'hFFFF,  q: 16'd1,     r: 16'd0,     dz: 1'b0};
        vecs[6]  = '{a: 16'd1234,  b: 16'd1,     q: 16'd1234,  r: 16'd0,     dz: 1'b0};
        vecs[7]  = '{a: 16'd7,     b: 16'd8,     q: 16'd0,     r: 16'd7,     dz: 1'b0};
        vecs[8]  = '{a: 16'h8000,  b: 16'd2,     q: 16'h4000,  r: 16'd0,     dz: 1'b0};
        vecs[9]  = '{a: 16'hFFFE,  b: 16'hFFFF,  q: 16'd0,     r: 16'hFFFE,  dz: 1'b0};
        vecs[10] = '{a: 16'd0,     b: 16'd0,     q: 16'hFFFF,  r: 16'd0,     dz: 1'b1};
        vecs[11] = '{a: 16'd40000, b: 16'd200,   q: 16'd200,   r: 16'd0,     dz: 1'b0};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", ready, 1);
        chk("reset_done", done, 0);
        chk("reset_quotient", quotient, 0);
        chk("reset_remainder", remainder, 0);
        chk("reset_dz", div_by_zero, 0);

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);
            if (vecs[i].dz) chk("dz_ready_stays", ready, 1);
            wait_idle();
        end

        // A request while busy must not disturb the division in flight.
        do_op(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0);
        repeat (4) @(posedge clk);
        #1 dividend = 16'd9;
        divisor = 16'd9;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle();

        // Reset mid-operation discards the result with no done pulse.
        do_op(16'd50000, 16'd123, 16'd406, 16'd62, 1'b0);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", ready, 1);
        chk("rst_mid_quotient", quotient, 0);
        chk("rst_mid_remainder", remainder, 0);
        chk("rst_mid_done", done, 0);
        repeat (20) @(negedge clk);
        do_op(16'd50000, 16'd123, 16'd406, 16'd62, 1'b0);
        wait_idle();

        // Reset beats a simultaneous start.
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        dividend = 16'd10;
        divisor = 16'd3;
        @(posedge clk);
        #1 rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_start_ready", ready, 1);
        chk("rst_start_quotient", quotient, 0);
        repeat (20) @(negedge clk);

        // Start held high: each accept follows its predecessor's result cycle directly.
        for (int i = 0; i < 1000; i++) begin
            wait_ready();
            a = 16'($urandom);
            b = $urandom_range(0, 1) ? 16'($urandom_range(1, 255)) : 16'($urandom);
            if (b == 0) b = 16'd1;
            dividend = a;
            divisor = b;
            start = 1'b1;
            @(posedge clk);
            #1 push_exp(a, b, a / b, a % b, 1'b0);
        end
        start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
